cpeta_adder: RTL and testbench



---
 rtl/cpeta_adder.sv | 127 ++++++++++++
 tb/tb_cpeta_adder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpeta_adder.sv
// -----------------------------------------------------------------------------
// cpeta_adder
//
// Registered N-bit carry-predicting error-tolerant approximate adder.
//
// The sum is split in two parts that are evaluated in parallel:
//   * Lower K bits: error-tolerant, no carry chain. Scanning from bit K-1 down,
//     every bit above the first position where A and B are both 1 is the plain
//     XOR of the operands. That position and every bit below it are forced to 1.
//     If no such position exists, the lower part is the exact XOR.
//   * Upper N-K bits: exact addition of A[N-1:K] + B[N-1:K] plus a carry that
//     is predicted from bit K-1 alone (A[K-1] & B[K-1]). The carry-out is
//     dropped, so the result wraps modulo 2^N.
//
// One cycle of latency, one operation per cycle, no backpressure.
//
// Parameters:
//   N  operand / sum width, N >= 2
//   K  width of the approximate lower part, 1 <= K <= N-1
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears sum and out_valid)
//   in_valid   A/B carry a valid operation this cycle
//   A, B       unsigned operands, N bits
//   sum        registered approximate sum, N bits (held while in_valid is low)
//   out_valid  sum holds the result of the operation captured on the last edge
// -----------------------------------------------------------------------------
module cpeta_adder #(
  parameter int N = 16,
  parameter int K = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] sum,
  output logic         out_valid
);

  // Reject illegal geometries at elaboration time.
  generate
    if (N < 2) begin : gen_bad_n
      $error("cpeta_adder: N must be at least 2");
    end
    if (K < 1 || K > N - 1) begin : gen_bad_k
      $error("cpeta_adder: K must satisfy 1 <= K <= N-1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Lower part
  // ---------------------------------------------------------------------------
  logic [K-1:0] gen_bit;    // both operand bits set at this position
  logic [K-1:0] prop_bit;   // plain XOR of the operand bits
  logic [K:0]   hit_chain;  // 1 when a generate was seen at this bit or above
  logic [K-1:0] lsum_next;

  assign gen_bit  = A[K-1:0] & B[K-1:0];
  assign prop_bit = A[K-1:0] ^ B[K-1:0];

  // Nothing lies above bit K-1 within the lower part.
  assign hit_chain[K] = 1'b0;

  // The "seen a generate" flag flows downward from the MSB of the lower part.
  // It is an OR prefix, not a carry: no bit's value depends on a lower bit.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : gen_lower
      assign hit_chain[gi] = hit_chain[gi+1] | gen_bit[gi];
      // Once the first generate is reached, this bit and all below it are 1;
      // above it the bit is the XOR. hit | xor covers both cases.
      assign lsum_next[gi] = hit_chain[gi] | prop_bit[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Carry prediction and upper part
  // ---------------------------------------------------------------------------
  // Predicted carry looks only at bit K-1; lower bits never ripple upward.
  logic cp;
  assign cp = A[K-1] & B[K-1];

  logic [N-K-1:0] a_hi;
  logic [N-K-1:0] b_hi;
  logic [N-K-1:0] cp_ext;
  logic [N-K-1:0] usum_next;

  assign a_hi = A[N-1:K];
  assign b_hi = B[N-1:K];

  // Zero-extend cp without a replication, which would be zero-width when
  // the upper part is a single bit.
  always_comb begin
    cp_ext    = '0;
    cp_ext[0] = cp;
  end

  // Same-width addition truncates the carry-out, giving the modulo-2^N wrap.
  assign usum_next = a_hi + b_hi + cp_ext;

  logic [N-1:0] sum_next;
  assign sum_next = {usum_next, lsum_next};

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [N-1:0] sum_reg;
  logic         out_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      // sum only updates on a valid operation; otherwise it holds.
      if (in_valid) begin
        sum_reg <= sum_next;
      end
    end
  end

  assign sum       = sum_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_cpeta_adder.sv
// -----------------------------------------------------------------------------
// tb_cpeta_adder
//
// Self-checking bench for cpeta_adder with N=16, K=9. Each applied operation
// pushes the reference result onto a queue; one cycle later the DUT output
// is popped against it. Directed cases cover reset, lower-part generates,
// the predicted carry and wrap-around; a random stream covers back-to-back
// throughput and accumulates error statistics against the exact sum.
// -----------------------------------------------------------------------------
module tb_cpeta_adder;

  localparam int N        = 16;
  localparam int K        = 9;
  localparam int N_RANDOM = 2000;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic [N-1:0] sum;
  logic         out_valid;

  int checks;
  int failures;
  int txn;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_sum;

  // error statistics
  int  err_count;
  int  stat_count;
  real sum_ed;
  real sum_red;
  int  red_count;
  int  max_ed;

  cpeta_adder #(.N(N), .K(K)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (a_in),
    .B        (b_in),
    .sum      (sum),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bit scan of the lower part, integer arithmetic for the upper.
  function automatic logic [N-1:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [K-1:0] lo;
    logic         seen;
    int           up;
    logic [N-1:0] res;
    seen = 1'b0;
    lo   = '0;
    for (int i = K - 1; i >= 0; i--) begin
      if (a[i] && b[i]) seen = 1'b1;
      lo[i] = seen ? 1'b1 : (a[i] ^ b[i]);
    end
    up  = (int'(a >> K) + int'(b >> K) + ((a[K-1] && b[K-1]) ? 1 : 0)) % (1 << (N - K));
    res = N'((up << K) | int'(lo));
    return res;
  endfunction

  // Drive one cycle of stimulus (no comparison here). Inputs change on the
  // falling edge; returns #1 after the capturing rising edge.
  task automatic apply(input logic [N-1:0] a, input logic [N-1:0] b, input logic v);
    @(negedge clk);
    a_in     = a;
    b_in     = b;
    in_valid = v;
    if (v) exp_q.push_back(ref_sum(a, b));
    @(posedge clk);
    #1;
    txn++;
  endtask

  task automatic test_reset;
    logic [N-1:0] exp;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a_in     = '0;
    b_in     = '0;
    #12;
    checks++;
    if (sum !== 16'h0000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: sum=%h out_valid=%b, required sum=0000 out_valid=0", sum, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(16'h1234, 16'h4000, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (sum !== exp || sum !== 16'h5234 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first: sum=%h out_valid=%b, required sum=5234 out_valid=1", sum, out_valid);
    end
    $display("txn %0d A=1234 B=4000 sum=%h exp=5234", txn, sum);
    last_sum = 16'h5234;
  endtask

  task automatic test_directed;
    logic [N-1:0] av[4];
    logic [N-1:0] bv[4];
    logic [N-1:0] rv[4];
    logic [N-1:0] exp;
    av = '{16'h00FF, 16'h0100, 16'hFFFF, 16'hFF00};
    bv = '{16'h0001, 16'h0100, 16'h0001, 16'h0100};
    rv = '{16'h00FF, 16'h03FF, 16'hFFFF, 16'h01FF};
    for (int i = 0; i < 4; i++) begin
      apply(av[i], bv[i], 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (sum !== rv[i] || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL directed_%0d: A=%h B=%h sum=%h out_valid=%b, required sum=%h out_valid=1",
                 i, av[i], bv[i], sum, out_valid, rv[i]);
      end
      checks++;
      if (exp !== rv[i]) begin
        failures++;
        $display("FAIL model_%0d: model=%h, required %h", i, exp, rv[i]);
      end
      $display("txn %0d A=%h B=%h sum=%h exp=%h", txn, av[i], bv[i], sum, rv[i]);
      last_sum = rv[i];
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp;
    int           exact;
    int           ed;
    for (int i = 0; i < N_RANDOM; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      apply(a, b, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (sum !== exp || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL stream_%0d: A=%h B=%h sum=%h out_valid=%b, required sum=%h out_valid=1",
                 i, a, b, sum, out_valid, exp);
      end
      $display("txn %0d A=%h B=%h sum=%h exp=%h", txn, a, b, sum, exp);
      last_sum = exp;
      exact = (int'(a) + int'(b)) % (1 << N);
      ed    = (exact > int'(exp)) ? exact - int'(exp) : int'(exp) - exact;
      stat_count++;
      if (ed != 0) err_count++;
      sum_ed += real'(ed);
      if (ed > max_ed) max_ed = ed;
      if (exact != 0) begin
        sum_red += real'(ed) / real'(exact);
        red_count++;
      end
    end
  endtask

  task automatic test_bubble;
    logic [N-1:0] exp;
    apply(16'h0F0F, 16'h1111, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (sum !== exp || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bubble_pre: sum=%h out_valid=%b, required sum=%h out_valid=1", sum, out_valid, exp);
    end
    $display("txn %0d A=0f0f B=1111 sum=%h exp=%h", txn, sum, exp);
    last_sum = exp;
    // Operands change while invalid; the held sum must ignore them.
    apply(16'hABCD, 16'h5555, 1'b0);
    checks++;
    if (sum !== last_sum || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bubble_hold: sum=%h out_valid=%b, required sum=%h out_valid=0", sum, out_valid, last_sum);
    end
    $display("txn %0d idle sum=%h exp=%h out_valid=%b", txn, sum, last_sum, out_valid);
    apply(16'h0001, 16'h0002, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (sum !== 16'h0003 || sum !== exp || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bubble_post: sum=%h out_valid=%b, required sum=0003 out_valid=1", sum, out_valid);
    end
    $display("txn %0d A=0001 B=0002 sum=%h exp=0003", txn, sum);
  endtask

  task automatic test_reset_midstream;
    apply(16'h7777, 16'h0808, 1'b1);
    void'(exp_q.pop_front());
    // Reset lands between edges while in_valid is still high.
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sum !== 16'h0000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: sum=%h out_valid=%b, required sum=0000 out_valid=0", sum, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sum !== 16'h0000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: sum=%h out_valid=%b, required sum=0000 out_valid=0", sum, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(16'h1234, 16'h4000, 1'b1);
    void'(exp_q.pop_front());
    checks++;
    if (sum !== 16'h5234 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: sum=%h out_valid=%b, required sum=5234 out_valid=1", sum, out_valid);
    end
    $display("txn %0d A=1234 B=4000 sum=%h exp=5234 (after reset)", txn, sum);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    txn        = 0;
    err_count  = 0;
    stat_count = 0;
    sum_ed     = 0.0;
    sum_red    = 0.0;
    red_count  = 0;
    max_ed     = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_bubble();
    test_reset_midstream();
    $display("stats: samples=%0d ER=%f MED=%f MRED=%f NMED=%f max_ed=%0d",
             stat_count,
             real'(err_count) / real'(stat_count),
             sum_ed / real'(stat_count),
             (red_count > 0) ? sum_red / real'(red_count) : 0.0,
             (max_ed > 0) ? (sum_ed / real'(stat_count)) / real'(max_ed) : 0.0,
             max_ed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
